// File: rtl/led_fade_driver_if.sv
// LED fade driver bus.
// Groups the pattern input, the enable, the PWM pin drive and the busy flag.
//   lights  : target pattern, 1 = LED on (master -> slave)
//   enable  : 0 blanks the pins and freezes ramping (master -> slave)
//   led_out : PWM pin drive (slave -> master)
//   busy    : some LED is still fading (slave -> master)
interface led_fade_driver_if #(
  parameter int NLED = 16
);
  logic [NLED-1:0] lights;
  logic            enable;
  logic [NLED-1:0] led_out;
  logic            busy;

  modport master (output lights, output enable, input led_out, input busy);
  modport slave  (input lights, input enable, output led_out, output busy);
endinterface

// File: rtl/led_fade_driver.sv
// led_fade_driver
// Ramps a per-LED brightness level toward the on/off target taken from the
// LED pattern register, and drives each pin with PWM at that level, so that
// pattern rewrites appear as smooth fades.
//
// Ports:
//   clock   : system clock, all logic on posedge
//   reset_n : synchronous active-low reset
//   bus     : led_fade_driver_if.slave (lights, enable, led_out, busy)
//
// Build option: define LED_GAMMA_EN to map level to duty through a square
// law (duty = level*level >> PWM_BITS, full level still fully on). Without
// it, duty equals level.
module led_fade_driver #(
  parameter int NLED     = 16,
  parameter int PWM_BITS = 4,
  parameter int RAMP_DIV = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  led_fade_driver_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] LMAX = '1;
  // Keep the prescaler at least one bit wide so RAMP_DIV=1 stays legal.
  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

  logic [NLED-1:0]     target_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [PRE_W-1:0]    presc_reg;
  logic [NLED-1:0]     led_out_reg;
  logic [NLED-1:0]     led_next;
  logic [NLED-1:0]     pending;
  logic                tick;

  assign tick = bus.enable && (presc_reg == PRE_LAST);

  // Target capture, free-running PWM counter and enable-gated prescaler.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      target_reg  <= '0;
      pwm_cnt_reg <= '0;
      presc_reg   <= '0;
      led_out_reg <= '0;
    end else begin
      target_reg  <= bus.lights;
      pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      if (tick) begin
        presc_reg <= '0;
      end else if (bus.enable) begin
        presc_reg <= presc_reg + 1'b1;
      end
      led_out_reg <= led_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NLED; gi++) begin : g_led
      logic [PWM_BITS-1:0] level_reg;
      logic [PWM_BITS-1:0] duty;

      // Saturating ramp toward the captured target, one step per tick.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          level_reg <= '0;
        end else if (tick) begin
          if (target_reg[gi] && (level_reg != LMAX)) begin
            level_reg <= level_reg + 1'b1;
          end else if (!target_reg[gi] && (level_reg != '0)) begin
            level_reg <= level_reg - 1'b1;
          end
        end
      end

`ifdef LED_GAMMA_EN
      logic [2*PWM_BITS-1:0] level_sq;
      assign level_sq = {{PWM_BITS{1'b0}}, level_reg} * {{PWM_BITS{1'b0}}, level_reg};
      assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
      assign duty = level_reg;
`endif

      // Full level is forced on so it never shows the one dark PWM slot.
      assign led_next[gi] = bus.enable && ((level_reg == LMAX) || (duty > pwm_cnt_reg));
      assign pending[gi]  = target_reg[gi] ? (level_reg != LMAX) : (level_reg != '0);
    end
  endgenerate

  assign bus.led_out = led_out_reg;
  assign bus.busy    = |pending;

endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;

  localparam int NLED     = 16;
  localparam int PWM_BITS = 4;
  localparam int RAMP_DIV = 4;
  localparam int LMAX     = (1 << PWM_BITS) - 1;
  localparam int PERIOD   = 1 << PWM_BITS;

  logic clock;
  logic reset_n;

  led_fade_driver_if #(.NLED(NLED)) bus ();

  led_fade_driver #(
    .NLED(NLED),
    .PWM_BITS(PWM_BITS),
    .RAMP_DIV(RAMP_DIV)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: brightness per LED as plain integers.
  int            mlev [NLED];
  bit [NLED-1:0] mtgt;
  int            mpwm;
  int            mpre;
  bit [NLED-1:0] m_led;

  function automatic int duty_of(input int lvl);
`ifdef LED_GAMMA_EN
    return (lvl * lvl) / PERIOD;
`else
    return lvl;
`endif
  endfunction

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int i = 0; i < NLED; i++) begin
      if (mtgt[i] && mlev[i] != LMAX) b = 1'b1;
      if (!mtgt[i] && mlev[i] != 0) b = 1'b1;
    end
    return b;
  endfunction

  task automatic model_edge(input bit rn, input bit [NLED-1:0] li, input bit en);
    bit tk;
    if (!rn) begin
      for (int i = 0; i < NLED; i++) mlev[i] = 0;
      mtgt  = '0;
      mpwm  = 0;
      mpre  = 0;
      m_led = '0;
    end else begin
      tk = en && (mpre == RAMP_DIV - 1);
      for (int i = 0; i < NLED; i++)
        m_led[i] = en && (mlev[i] == LMAX || duty_of(mlev[i]) > mpwm);
      if (tk) begin
        for (int i = 0; i < NLED; i++) begin
          if (mtgt[i]) mlev[i] = (mlev[i] < LMAX) ? mlev[i] + 1 : LMAX;
          else         mlev[i] = (mlev[i] > 0) ? mlev[i] - 1 : 0;
        end
      end
      if (en) mpre = tk ? 0 : mpre + 1;
      mpwm = (mpwm + 1) % PERIOD;
      mtgt = li;
    end
  endtask

  task automatic check(input string tag, input logic [NLED-1:0] obs, input logic [NLED-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  // One clock: apply inputs, take the edge, advance the model, compare pins.
  task automatic step(input logic rn, input logic [NLED-1:0] li, input logic en);
    reset_n    = rn;
    bus.lights = li;
    bus.enable = en;
    @(posedge clock);
    model_edge(rn, li, en);
    #1;
    check("led_out", bus.led_out, m_led);
    check("busy", {{(NLED-1){1'b0}}, bus.busy}, {{(NLED-1){1'b0}}, model_busy()});
    $display("t=%0t rst_n=%0b lights=%h en=%0b led_out=%h busy=%0b lvl0=%0d",
             $time, rn, li, en, bus.led_out, bus.busy, mlev[0]);
  endtask

  initial begin
    int n;
    int high_cnt;
    logic [NLED-1:0] rl;
    logic ren;
    logic rrn;

    for (int i = 0; i < NLED; i++) mlev[i] = 0;
    mtgt = '0; mpwm = 0; mpre = 0; m_led = '0;
    reset_n = 1'b0; bus.lights = '0; bus.enable = 1'b1;

    // Reset with all targets on: outputs and busy stay low.
    for (int k = 0; k < 3; k++) step(1'b0, 16'hFFFF, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 16'hFFFF, 1'b1);
    step(1'b0, 16'h0001, 1'b1);

    // Fade up LED0 to full and hold.
    for (int k = 0; k < 80; k++) step(1'b1, 16'h0001, 1'b1);

    // Duty check at full: LED0 continuously on across a whole PWM period.
    high_cnt = 0;
    for (int k = 0; k < PERIOD; k++) begin
      step(1'b1, 16'h0001, 1'b1);
      if (bus.led_out[0]) high_cnt++;
    end
    check("full_duty", NLED'(high_cnt), NLED'(PERIOD));

    // Fade down, reverse at level 9 and ride back up until idle.
    n = 0;
    while (mlev[0] != 9 && n < 200) begin
      step(1'b1, 16'h0000, 1'b1);
      n++;
    end
    check("reach_lvl9", NLED'(n < 200), NLED'(1));
    n = 0;
    while ((model_busy() || n < 2) && n < 200) begin
      step(1'b1, 16'h0001, 1'b1);
      n++;
    end
    check("reverse_done", NLED'(n < 200), NLED'(1));

    // Enable gating at level 6, then resume.
    n = 0;
    while (mlev[0] != 6 && n < 200) begin
      step(1'b1, 16'h0000, 1'b1);
      n++;
    end
    for (int k = 0; k < 100; k++) step(1'b1, 16'h0001, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 16'h0001, 1'b1);

    // Mid-ramp reset at level 11, ramp restarts from 0.
    n = 0;
    while (mlev[0] != 11 && n < 200) begin
      step(1'b1, 16'h0001, 1'b1);
      n++;
    end
    step(1'b0, 16'h0001, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 16'h0001, 1'b1);

    // Randomized traffic against the model.
    rl = 16'h0000; ren = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 39) == 0) rl = NLED'($urandom);
      ren = ($urandom_range(0, 9) != 0);
      rrn = ($urandom_range(0, 499) != 0);
      step(rrn, rl, ren);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream consumer of the CPU-written 16-bit LED pattern register.
- Each bit is the on/off target of one LED; the block ramps a per-LED brightness level toward that target at a programmable rate.
- Drives the board LED pins with PWM at the resulting duty.
- Gives smooth fades instead of hard toggles when software rewrites the pattern.

Parameters:
- NLED, 16: number of LEDs; width of the pattern input and the pin output.
- PWM_BITS, 4: width of the brightness level and the PWM counter. PWM period is 2^PWM_BITS cycles. LMAX = 2^PWM_BITS-1.
- RAMP_DIV, 4: clocks between ramp ticks; must be >= 1.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset_n  input  1  synchronous, active-low reset.
- lights  input  NLED  target pattern from the LED register; 1 = on.
- enable  input  1  0 blanks the outputs and freezes ramping.
- led_out  output  NLED  PWM-modulated LED pin drive, registered.
- busy  output  1  1 while any LED level has not reached its target endpoint.

Behaviour:
- Reset: while reset_n=0 at a posedge, clear target register, all levels, pwm_cnt, prescaler and led_out to 0. busy=0. Reset asserted mid-ramp aborts the ramp the same edge; no partial state survives.
- Input capture: target <= lights every cycle, giving 1 cycle of latency. No handshake; the input is level-sampled.
- PWM counter:
  - pwm_cnt (PWM_BITS wide) increments every cycle, independent of enable.
  - Wraps LMAX -> 0.
- Prescaler:
  - Counts 0..RAMP_DIV-1 only while enable=1.
  - tick = (prescaler==RAMP_DIV-1) && enable. The prescaler returns to 0 on tick.
  - RAMP_DIV=1 gives a tick every enabled cycle.
- Level update, per LED i, on tick only:
  - target[i]=1 and level[i]<LMAX: level+1.
  - target[i]=0 and level[i]>0: level-1.
  - Otherwise hold. Saturating; never wraps.
  - A target change mid-ramp reverses direction from the current level on the next tick.
- Duty compare (registered into led_out):
  - duty[i] = level[i] (see Optional Feature).
  - led_out[i] <= enable && ((level[i]==LMAX) || (duty[i] > pwm_cnt)).
  - level 0: always off. LMAX: always on. level L: high for L of every 2^PWM_BITS cycles, at pwm_cnt = 0..L-1.
- Latency: lights change sampled at edge k -> target at k. The first possible level change is at the first tick at or after k+1. led_out reflects the new level one edge after the level changes.
- enable=0: led_out=0 from the next edge. Levels and prescaler are held. pwm_cnt runs. On re-enable, ramping resumes from the held levels and prescaler value.
- busy is combinational from registers: OR over i of (target[i] ? level[i]!=LMAX : level[i]!=0). busy stays valid while enable=0.
- Full fade time: LMAX ticks = LMAX*RAMP_DIV enabled cycles (60 at defaults).

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: duty[i] = (level[i]*level[i]) >> PWM_BITS for level[i]<LMAX. LMAX is still forced fully on.
  - Defaults: level 8 -> duty 4; level 3 -> duty 0; level 14 -> duty 12.
- Undefined: duty[i] = level[i] (linear).
- Ramp timing and busy are identical in both builds.

Test Plan:
- Reset: reset_n=0 for 3 cycles with lights=16'hFFFF -> led_out=0, busy=0 throughout. After release, target and busy go to 1 on the first edge; level[0] reaches 1 after 4 cycles.
- Fade up: from reset, lights=16'h0001 -> level[0]=15 after 60 cycles. led_out[0] then stays 1 continuously, busy=0, and led_out[15:1]=0 at all times.
- Duty check: freeze level[0]=8 with enable held high and lights stable -> led_out[0] high exactly for pwm_cnt 0..7 (8 of 16 cycles). With LED_GAMMA_EN defined -> high for pwm_cnt 0..3 only.
- Fade down and reversal: from full, lights=16'h0000 -> level decrements each 4 cycles. At level 9, set lights=16'h0001 -> the next tick gives level 10, and busy stays 1 until level 15.
- Enable gating: set enable=0 at level 6 -> led_out=0 on the next edge and level stays 6 for 100 cycles. Re-enable -> level 7 after the remaining prescaler count.
- Mid-ramp reset: reset_n=0 for 1 cycle at level 11 -> all levels 0, led_out=0. With lights still 16'h0001, busy=1 after release and the ramp restarts from 0.
